// File: rtl/playfield_rows.sv
// Row-stack playfield: OR-merges cells into rows and removes full rows, shifting the stack down.
// Optional PLAYFIELD_TOTAL_LINES_EN adds a saturating 16-bit running total of cleared rows.
module playfield_rows #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  localparam int IDX_W = $clog2(ROWS),
  localparam int CNT_W = $clog2(ROWS + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_row_i,
  input  logic [COLS-1:0]  wr_data_i,
  input  logic             start_i,
  input  logic [IDX_W-1:0] rd_row_i,
  output logic [COLS-1:0]  rd_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] lines_cleared_o,
  output logic             collide_o,
`ifdef PLAYFIELD_TOTAL_LINES_EN
  output logic [15:0]      total_lines_o,
`endif
  output logic [1:0]       debug_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COLLAPSE, S_FINISH} state_t;

  // Handshake: wr_en_i/start_i are single-cycle requests sampled on the rising
  // edge; they are accepted only while busy_o is low, otherwise dropped.
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic             collide_q, collide_d;
  logic [COLS-1:0]  rows_q [ROWS];
  logic [COLS-1:0]  rows_d [ROWS];
  logic             merge_ok;
  logic             row_full;

`ifdef PLAYFIELD_TOTAL_LINES_EN
  logic [15:0] total_q, total_d;
  logic [16:0] total_sum;
`endif

  assign merge_ok = (state_q == S_IDLE) && wr_en_i && (int'(wr_row_i) < ROWS);
  assign row_full = (rows_q[idx_q] == {COLS{1'b1}});

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    lines_d   = lines_q;
    collide_d = 1'b0;
    rows_d    = rows_q;
`ifdef PLAYFIELD_TOTAL_LINES_EN
    total_d   = total_q;
    total_sum = {1'b0, total_q} + 17'(count_q);
`endif
    case (state_q)
      S_IDLE: begin
        if (merge_ok) begin
          rows_d[wr_row_i] = rows_q[wr_row_i] | wr_data_i;
          collide_d        = |(rows_q[wr_row_i] & wr_data_i);
        end
        if (start_i) begin
          state_d = S_SCAN;
          idx_d   = IDX_W'(ROWS - 1);
          count_d = '0;
        end
      end
      S_SCAN: begin
        if (row_full) begin
          state_d = S_COLLAPSE;
        end else if (idx_q == '0) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_COLLAPSE: begin
        // Everything above the full row drops by one; row i is re-scanned next.
        for (int k = 1; k < ROWS; k++) begin
          if (k <= int'(idx_q)) rows_d[k] = rows_q[k-1];
        end
        rows_d[0] = '0;
        count_d   = count_q + 1'b1;
        state_d   = S_SCAN;
      end
      S_FINISH: begin
        lines_d = count_q;
        state_d = S_IDLE;
`ifdef PLAYFIELD_TOTAL_LINES_EN
        total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      lines_q   <= '0;
      collide_q <= 1'b0;
      for (int k = 0; k < ROWS; k++) rows_q[k] <= '0;
`ifdef PLAYFIELD_TOTAL_LINES_EN
      total_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      lines_q   <= lines_d;
      collide_q <= collide_d;
      for (int k = 0; k < ROWS; k++) rows_q[k] <= rows_d[k];
`ifdef PLAYFIELD_TOTAL_LINES_EN
      total_q   <= total_d;
`endif
    end
  end

  assign rd_data_o       = rows_q[rd_row_i];
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_FINISH);
  assign lines_cleared_o = lines_q;
  assign collide_o       = collide_q;
  assign debug_state_o   = state_q;
`ifdef PLAYFIELD_TOTAL_LINES_EN
  assign total_lines_o   = total_q;
`endif

endmodule

// File: tb/tb_playfield_rows.sv
// Bench for playfield_rows: directed scenarios plus random merge/scan rounds
// checked against a row-list model of the playfield.
module tb_playfield_rows;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam logic [COLS-1:0] FULL = 10'h3FF;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_row = '0;
  logic [9:0] wr_data = '0;
  logic       start = 1'b0;
  logic [4:0] rd_row = '0;
  logic [9:0] rd_data;
  logic       busy, done, collide;
  logic [4:0] lines_cleared;
  logic [1:0] debug_state;
`ifdef PLAYFIELD_TOTAL_LINES_EN
  logic [15:0] total_lines;
`endif

  playfield_rows #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk_i(clk),
    .reset_i(reset),
    .wr_en_i(wr_en),
    .wr_row_i(wr_row),
    .wr_data_i(wr_data),
    .start_i(start),
    .rd_row_i(rd_row),
    .rd_data_o(rd_data),
    .busy_o(busy),
    .done_o(done),
    .lines_cleared_o(lines_cleared),
    .collide_o(collide),
`ifdef PLAYFIELD_TOTAL_LINES_EN
    .total_lines_o(total_lines),
`endif
    .debug_state_o(debug_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [COLS-1:0] model_rows [ROWS];
  int model_total = 0;
  logic [4:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++) model_rows[r] = '0;
  endfunction

  // Full rows vanish; survivors keep their order and sink to the bottom.
  function automatic int model_scan();
    logic [COLS-1:0] keep[$];
    int k = 0;
    for (int r = 0; r < ROWS; r++) begin
      if (model_rows[r] == FULL) k++;
      else keep.push_back(model_rows[r]);
    end
    for (int r = 0; r < ROWS; r++) model_rows[r] = (r < k) ? '0 : keep[r-k];
    model_total = (model_total + k > 65535) ? 65535 : model_total + k;
    return k;
  endfunction

  task automatic check_rows(input string tag);
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      rd_row = r[4:0];
      #1;
      check_eq($sformatf("%s_row%0d", tag, r), 32'(rd_data), 32'(model_rows[r]));
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b1; wr_row = 5'd0; wr_data = FULL; start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; wr_en = 1'b0; start = 1'b0;
    model_clear();
    model_total = 0;
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_collide", 32'(collide), 0);
    check_eq("rst_lines", 32'(lines_cleared), 0);
`ifdef PLAYFIELD_TOTAL_LINES_EN
    check_eq("rst_total", 32'(total_lines), 0);
`endif
  endtask

  task automatic do_merge(input int row, input logic [9:0] data);
    logic exp_col;
    @(negedge clk);
    wr_en = 1'b1; wr_row = row[4:0]; wr_data = data;
    exp_col = 1'b0;
    if (row < ROWS) begin
      exp_col = |(model_rows[row] & data);
      model_rows[row] = model_rows[row] | data;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    check_eq("collide", 32'(collide), 32'(exp_col));
    if (row < ROWS) begin
      rd_row = row[4:0];
      #1;
      check_eq("merge_row", 32'(rd_data), 32'(model_rows[row]));
    end
  endtask

  task automatic do_scan(input bit with_merge, input int mrow, input logic [9:0] mdata, input bit inject);
    int n;
    int k;
    bit seen;
    logic exp_col;
    @(negedge clk);
    start = 1'b1;
    exp_col = 1'b0;
    if (with_merge) begin
      wr_en = 1'b1; wr_row = mrow[4:0]; wr_data = mdata;
      exp_col = |(model_rows[mrow] & mdata);
      model_rows[mrow] = model_rows[mrow] | mdata;
    end
    k = model_scan();
    exp_q.push_back(5'(k));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0; wr_en = 1'b0;
      if (n == 1) begin
        check_eq("scan_busy", 32'(busy), 1);
        check_eq("scan_merge_collide", 32'(collide), 32'(exp_col));
      end
      if (n == 4 && inject) check_eq("busy_collide", 32'(collide), 0);
      if (n == 3 && inject) begin
        wr_en = 1'b1; wr_row = 5'd3; wr_data = FULL; start = 1'b1;
      end
      seen = done;
    end
    check_eq("latency", 32'(n), 32'(ROWS + 2 * k + 1));
    @(posedge clk);
    #1;
    check_eq("post_busy", 32'(busy), 0);
    check_eq("post_done", 32'(done), 0);
    check_eq("lines_cleared", 32'(lines_cleared), 32'(exp_q.pop_front()));
`ifdef PLAYFIELD_TOTAL_LINES_EN
    check_eq("total_lines", 32'(total_lines), 32'(model_total));
`endif
    check_rows("scan");
  endtask

  initial begin
    int dones;
    model_clear();
    reset_dut();
    check_rows("reset");

    // single full row at the bottom
    do_merge(19, FULL);
    do_scan(1'b0, 0, '0, 1'b0);

    // two adjacent full rows with a partial row above
    do_merge(18, FULL);
    do_merge(19, FULL);
    do_merge(17, 10'h001);
    do_scan(1'b0, 0, '0, 1'b0);

    // overlapping merges into one row
    do_merge(5, 10'h00F);
    do_merge(5, 10'h018);

    // requests while busy are dropped; merge+start in the same idle cycle
    do_scan(1'b0, 0, '0, 1'b1);
    do_scan(1'b1, 19, FULL, 1'b0);

    // out-of-range row is ignored
    do_merge(21, FULL);

    // scans clearing 1, 2 and 4 rows from a fresh stack
    reset_dut();
    do_merge(19, FULL);
    do_scan(1'b0, 0, '0, 1'b0);
    for (int r = 18; r < 20; r++) do_merge(r, FULL);
    do_scan(1'b0, 0, '0, 1'b0);
    for (int r = 16; r < 20; r++) do_merge(r, FULL);
    do_scan(1'b0, 0, '0, 1'b0);
    check_eq("three_scans_total", 32'(model_total), 7);

    // random rounds
    for (int round = 0; round < 6; round++) begin
      for (int m = 0; m < 14; m++) begin
        int row;
        logic [9:0] data;
        row = $urandom_range(0, 21);
        data = ($urandom_range(0, 2) == 0) ? FULL : 10'($urandom_range(0, 1023));
        do_merge(row, data);
      end
      do_scan(1'b0, 0, '0, 1'b0);
    end

    // reset two cycles into a scan
    do_merge(19, FULL);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    model_total = 0;
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_done", 32'(done), 0);
    check_eq("midrst_lines", 32'(lines_cleared), 0);
`ifdef PLAYFIELD_TOTAL_LINES_EN
    check_eq("midrst_total", 32'(total_lines), 0);
`endif
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check_eq("midrst_no_done", 32'(dones), 0);
    check_rows("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
